// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: op codes, FSM state encoding and register bus widths for the iterative mul/div unit
package mdu_iter_pkg;
  localparam int REG_BUS_W = 32;
  localparam int DOUBLE_REG_BUS_W = 2 * REG_BUS_W;
  localparam logic [1:0] MDU_MULU = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIVU = 2'b10;
  localparam logic [1:0] MDU_DIV  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: EX-stage request/result bundle of the mul/div unit
interface mdu_iter_if import mdu_iter_pkg::*; #(parameter int WIDTH = REG_BUS_W);
  logic start_i;
  logic annul_i;
  logic [1:0] op_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic ready_o;
  logic busy_o;
  logic div_zero_o;
  modport master (output start_i, annul_i, op_i, opdata1_i, opdata2_i, input result_o, ready_o, busy_o, div_zero_o);
  modport slave (input start_i, annul_i, op_i, opdata1_i, opdata2_i, output result_o, ready_o, busy_o, div_zero_o);
endinterface

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negation
module mdu_negate import mdu_iter_pkg::*; #(parameter int WIDTH = REG_BUS_W) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider, one bit per cycle; MDU_EARLY_TERM_EN ends multiplies once the remaining multiplier bits are zero
module mdu_iter import mdu_iter_pkg::*; #(
  parameter int WIDTH = REG_BUS_W,
  parameter bit ZERO_Q_ONES = 1'b0
) (
  input logic clk,
  input logic rst,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;
  state_t state, state_n;
  logic div_op, res_neg, rem_neg, dz, dz_in, start_ok, last;
  logic [WIDTH-1:0] a, m, abs1, abs2, fix_q, fix_r;
  logic [W2-1:0] acc, step, fix_p, result;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, t, diff;
  mdu_negate #(.WIDTH(WIDTH)) u_abs1 (.a(bus.opdata1_i), .neg(bus.op_i[0] & bus.opdata1_i[WIDTH-1]), .y(abs1));
  mdu_negate #(.WIDTH(WIDTH)) u_abs2 (.a(bus.opdata2_i), .neg(bus.op_i[0] & bus.opdata2_i[WIDTH-1]), .y(abs2));
  mdu_negate #(.WIDTH(WIDTH)) u_fix_q (.a(acc[WIDTH-1:0]), .neg(res_neg), .y(fix_q));
  mdu_negate #(.WIDTH(WIDTH)) u_fix_r (.a(acc[W2-1:WIDTH]), .neg(rem_neg), .y(fix_r));
  mdu_negate #(.WIDTH(W2)) u_fix_p (.a(acc), .neg(res_neg), .y(fix_p));
  assign start_ok = bus.start_i & ~bus.annul_i;
  assign dz_in = bus.op_i[1] & ~|bus.opdata2_i;
`ifdef MDU_EARLY_TERM_EN
  assign last = (cnt == CW'(WIDTH)) || (!div_op && m == '0);
`else
  assign last = cnt == CW'(WIDTH);
`endif
  // one iteration: add-and-shift-right for multiply, shift-left trial-subtract for divide
  always_comb begin
    sum = {1'b0, acc[W2-1:WIDTH]} + {1'b0, {WIDTH{m[0]}} & a};
    t = acc[W2-1:WIDTH-1];
    diff = t - {1'b0, a};
    step = div_op ? {diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]} : {sum, acc[WIDTH-1:1]};
  end
  // next state and status outputs
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = start_ok ? (dz_in ? S_DONE : S_BUSY) : S_IDLE;
      S_BUSY: state_n = bus.annul_i ? S_IDLE : (last ? S_FIX : S_BUSY);
      S_FIX:  state_n = bus.annul_i ? S_IDLE : S_DONE;
      default: state_n = bus.start_i ? S_DONE : S_IDLE;
    endcase
    bus.ready_o = state == S_DONE;
    bus.busy_o = state == S_BUSY || state == S_FIX;
    bus.div_zero_o = state == S_DONE && dz;
    bus.result_o = result;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_n;
  end
  // operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_op <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      dz <= 1'b0;
      a <= '0;
      m <= '0;
      acc <= '0;
      cnt <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          div_op <= bus.op_i[1];
          res_neg <= bus.op_i[0] & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          rem_neg <= bus.op_i[0] & bus.opdata1_i[WIDTH-1];
          dz <= dz_in;
          a <= bus.op_i[1] ? abs2 : abs1;
          m <= abs2;
          acc <= bus.op_i[1] ? {{WIDTH{1'b0}}, abs1} : '0;
          cnt <= '0;
          if (dz_in) result <= ZERO_Q_ONES ? {bus.opdata1_i, {WIDTH{1'b1}}} : '0;
        end
        S_BUSY: if (!last) begin
          acc <= step;
          m <= m >> 1;
          cnt <= cnt + 1'b1;
        end
`ifdef MDU_EARLY_TERM_EN
        else if (!div_op) acc <= acc >> (CW'(WIDTH) - cnt);
`endif
        S_FIX: if (!bus.annul_i) result <= div_op ? {fix_r, fix_q} : fix_p;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter at WIDTH=32 with both divide-by-zero policies
module tb_mdu_iter;
  import mdu_iter_pkg::*;
  typedef struct {logic [63:0] res; logic dz; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  exp_t sb[$];
  logic [63:0] last_res;
  always #5 clk = ~clk;
  mdu_iter_if #(.WIDTH(32)) b0 ();
  mdu_iter_if #(.WIDTH(32)) b1 ();
  mdu_iter #(.WIDTH(32), .ZERO_Q_ONES(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mdu_iter #(.WIDTH(32), .ZERO_Q_ONES(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  assign b1.start_i = b0.start_i;
  assign b1.annul_i = b0.annul_i;
  assign b1.op_i = b0.op_i;
  assign b1.opdata1_i = b0.opdata1_i;
  assign b1.opdata2_i = b0.opdata2_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = op[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = op[0] ? longint'($signed(b)) : longint'({32'd0, b});
    if (!op[1]) return 64'(sa * sb);
    if (b == 32'd0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input int hold);
    exp_t e;
    int k;
    logic [63:0] held;
    logic z;
    z = op[1] && b == 32'd0;
    sb.push_back('{res: exp, dz: z, lat: z ? 0 : 34});
    @(negedge clk);
    b0.op_i = op;
    b0.opdata1_i = a;
    b0.opdata2_i = b;
    b0.start_i = 1'b1;
    @(posedge clk);
    #1;
    b0.opdata1_i = $urandom;
    b0.opdata2_i = $urandom;
    k = 0;
    while (!b0.ready_o && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    e = sb.pop_front();
    chk("latency", 64'(k), 64'(e.lat));
    chk("result", b0.result_o, e.res);
    chk("div_zero", 64'(b0.div_zero_o), 64'(e.dz));
    if (e.dz) chk("zero_q_ones", b1.result_o, {a, 32'hFFFF_FFFF});
    held = b0.result_o;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      chk("hold_ready", 64'(b0.ready_o), 64'd1);
      chk("hold_result", b0.result_o, held);
    end
    @(negedge clk);
    b0.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_drop", 64'(b0.ready_o), 64'd0);
    chk("result_keep", b0.result_o, held);
    last_res = held;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    logic rose;
    b0.start_i = 1'b0;
    b0.annul_i = 1'b0;
    b0.op_i = 2'b00;
    b0.opdata1_i = '0;
    b0.opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", b0.result_o, 64'd0);
    chk("reset_flags", 64'({b0.ready_o, b0.busy_o, b0.div_zero_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    do_op(MDU_DIV, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    do_op(MDU_DIVU, 32'd5, 32'd0, 64'd0, 2);
    do_op(MDU_MUL, -32'sd3, 32'h7FFF_FFFF, 64'hFFFF_FFFE_8000_0003, 5);
    do_op(MDU_MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    do_op(MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      do_op(op, a, b, model(op, a, b), 0);
    end
    @(negedge clk);
    b0.op_i = MDU_MULU;
    b0.opdata1_i = 32'd1234;
    b0.opdata2_i = 32'd5678;
    b0.start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("annul_busy_before", 64'(b0.busy_o), 64'd1);
    b0.annul_i = 1'b1;
    b0.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("annul_busy_after", 64'(b0.busy_o), 64'd0);
    @(negedge clk);
    b0.annul_i = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      rose = rose | b0.ready_o;
    end
    chk("annul_no_ready", 64'(rose), 64'd0);
    chk("annul_result", b0.result_o, last_res);
    @(negedge clk);
    b0.op_i = MDU_DIVU;
    b0.opdata1_i = 32'd999;
    b0.opdata2_i = 32'd10;
    b0.start_i = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_busy_before", 64'(b0.busy_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_result", b0.result_o, 64'd0);
    chk("rst_flags", 64'({b0.ready_o, b0.busy_o, b0.div_zero_o}), 64'd0);
    @(negedge clk);
    b0.start_i = 1'b0;
    rst = 1'b1;
    do_op(MDU_DIVU, 32'd999, 32'd10, {32'd9, 32'd99}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
